sd_dac_sample_scheduler: RTL and testbench

- Feeds the 16-bit offset-binary sample input and clock-enable of the second_order_dac sigma-delta modulator from a valid/ready sample stream.
- Buffers samples in a small FIFO and paces their release at a programmable sample period; the modulator clock is unchanged.
- Sequences start-up (pre-fill at midscale), steady-state play with underrun handling, and click-free shutdown (ramp to midscale).
- Sits between the audio/tone source and the DAC core, in the same clock domain.

---
 rtl/sd_dac_pkg.sv | 15 +
 rtl/sd_dac_sample_fifo.sv | 55 +++++
 rtl/sd_dac_sample_scheduler.sv | 131 +++++++++++++
 tb/tb_sd_dac_sample_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dac_pkg.sv
// Shared types and constants for the sigma-delta DAC sample scheduler.
// State encoding is visible on o_state, so the values are fixed.
package sd_dac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] MIDSCALE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sd_dac_sample_fifo.sv
// Small synchronous sample FIFO with register storage and a combinational head.
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module sd_dac_sample_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) entry_reg <= wdata;
    end
    assign mem[gi] = entry_reg;
  end

endmodule

// File: rtl/sd_dac_sample_scheduler.sv
// Paces a valid/ready sample stream into the second_order_dac at a programmable
// sample period, with midscale pre-fill, underrun flagging and ramped shutdown.
module sd_dac_sample_scheduler
  import sd_dac_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12,
  parameter int RAMP_STEP  = 256
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_ce,
  output logic [DATA_W-1:0] o_func,
  output logic              o_sample_strobe,
  output logic              o_underrun,
  input  logic              i_clr_underrun,
  output logic [1:0]        o_state
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       HALF     = (AW+1)'(FIFO_DEPTH / 2);
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   MID_EXT  = {1'b0, MID};
  localparam logic [DATA_W:0]   STEP_EXT = (DATA_W+1)'(RAMP_STEP);

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] func_reg, func_next;
  logic              underrun_reg, underrun_next;
  logic              strobe_reg;

  logic              tick, push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [AW:0]       fifo_count;
  logic [DATA_W:0]   func_ext, ramp_up;
  logic [DATA_W-1:0] ramp_dn;

  // i_div is compared live, so shrinking it below cnt_reg fires on the next cycle.
  assign tick     = (state_reg != IDLE) && (cnt_reg >= i_div);
  assign cnt_next = ((state_reg == IDLE) || tick) ? '0 : cnt_reg + DIV_W'(1);

  assign o_s_ready = i_res && !fifo_full && (state_reg != DRAIN);
  assign push      = i_s_valid && o_s_ready;
  assign pop       = (state_reg == RUN) && tick && !fifo_empty;
  assign flush     = (state_reg == DRAIN);

  assign func_ext = {1'b0, func_reg};
  assign ramp_up  = func_ext + STEP_EXT;
  assign ramp_dn  = func_reg - DATA_W'(RAMP_STEP);

  sd_dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_res),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (i_s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next    = state_reg;
    func_next     = func_reg;
    underrun_next = underrun_reg && !i_clr_underrun;
    case (state_reg)
      IDLE: begin
        func_next = MID;
        if (i_enable) state_next = PRIME;
      end
      PRIME: begin
        func_next = MID;
        if (!i_enable) state_next = IDLE;
        else if (tick && (fifo_count >= HALF)) state_next = RUN;
      end
      RUN: begin
        if (pop) func_next = fifo_rdata;
        if (tick && fifo_empty) underrun_next = 1'b1;
        if (!i_enable) state_next = DRAIN;
      end
      DRAIN: begin
        // Step toward midscale, clamping the last step so it never overshoots.
        if (tick) begin
          if (func_ext > MID_EXT) begin
            func_next = (func_ext >= MID_EXT + STEP_EXT) ? ramp_dn : MID;
          end else if (func_ext < MID_EXT) begin
            func_next = (ramp_up <= MID_EXT) ? ramp_up[DATA_W-1:0] : MID;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      func_reg     <= MID;
      underrun_reg <= 1'b0;
      strobe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      func_reg     <= func_next;
      underrun_reg <= underrun_next;
      strobe_reg   <= pop;
    end
  end

  assign o_ce            = (state_reg != IDLE);
  assign o_func          = func_reg;
  assign o_sample_strobe = strobe_reg;
  assign o_underrun      = underrun_reg;
  assign o_state         = state_reg;

endmodule

// File: tb/tb_sd_dac_sample_scheduler.sv
// Scoreboard bench for sd_dac_sample_scheduler: queued samples are expected on
// o_func in push order, one per o_sample_strobe.
module tb_sd_dac_sample_scheduler;
  import sd_dac_pkg::*;

  localparam int DATA_W = 16;
  localparam int DIV_W  = 12;

  logic              i_clk = 1'b0;
  logic              i_res = 1'b1;
  logic              i_enable = 1'b0;
  logic [DIV_W-1:0]  i_div = '0;
  logic              i_s_valid = 1'b0;
  logic [DATA_W-1:0] i_s_data = '0;
  logic              i_clr_underrun = 1'b0;
  logic              o_s_ready, o_ce, o_sample_strobe, o_underrun;
  logic [DATA_W-1:0] o_func;
  logic [1:0]        o_state;

  int                checks = 0;
  int                errors = 0;
  int                n_samples = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  always #5 i_clk = ~i_clk;

  sd_dac_sample_scheduler #(
    .DATA_W (DATA_W), .FIFO_DEPTH (8), .DIV_W (DIV_W), .RAMP_STEP (256)
  ) dut (
    .i_clk (i_clk), .i_res (i_res), .i_enable (i_enable), .i_div (i_div),
    .i_s_valid (i_s_valid), .o_s_ready (o_s_ready), .i_s_data (i_s_data),
    .o_ce (o_ce), .o_func (o_func), .o_sample_strobe (o_sample_strobe),
    .o_underrun (o_underrun), .i_clr_underrun (i_clr_underrun), .o_state (o_state)
  );

  // Output side of the scoreboard: every strobe must deliver the oldest queued sample.
  always @(negedge i_clk) begin
    if (i_res && o_sample_strobe) begin
      checks++;
      n_samples++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected o_func=%h required=no strobe", o_func);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_func !== mon_exp) begin
          errors++;
          $display("FAIL sample_value o_func=%h required=%h", o_func, mon_exp);
        end else begin
          $display("sample %0d o_func=%h", n_samples, o_func);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_sample(input logic [DATA_W-1:0] d, input bit track);
    bit acc;
    acc = 1'b0;
    i_s_valid = 1'b1;
    i_s_data  = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = o_s_ready;
      @(negedge i_clk);
    end
    i_s_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept data=%h ready=%b required=accepted", d, o_s_ready);
    end else if (track) begin
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_strobe(input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      @(negedge i_clk);
      n++;
      ok = o_sample_strobe;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, output int n);
    n = 0;
    while (o_state !== st && n < bound) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2 i_res = 1'b0;
    i_div = 12'd9;
    repeat (3) @(negedge i_clk);
    checks++; if (o_func !== MIDSCALE) begin errors++; $display("FAIL rst_func o_func=%h required=%h", o_func, MIDSCALE); end
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rst_ce o_ce=%b required=0", o_ce); end
    checks++; if (o_s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready o_s_ready=%b required=0", o_s_ready); end
    checks++; if (o_sample_strobe !== 1'b0 || o_underrun !== 1'b0) begin errors++; $display("FAIL rst_flags strobe=%b underrun=%b required=0 0", o_sample_strobe, o_underrun); end
    i_res = 1'b1;
    @(negedge i_clk);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL idle_state o_state=%0d required=0", o_state); end
    checks++; if (o_ce !== 1'b0 || o_func !== MIDSCALE) begin errors++; $display("FAIL idle_out o_ce=%b o_func=%h required=0 8000", o_ce, o_func); end
    checks++; if (o_s_ready !== 1'b1) begin errors++; $display("FAIL idle_ready o_s_ready=%b required=1", o_s_ready); end
  endtask

  task automatic test_startup();
    logic [DATA_W-1:0] vals [4];
    int n;
    bit ok;
    vals = '{16'd80, 16'd32766, 16'd32770, 16'd65080};
    for (int k = 0; k < 4; k++) push_sample(vals[k], 1'b1);
    i_enable = 1'b1;
    @(negedge i_clk);
    checks++; if (o_state !== 2'd1 || o_ce !== 1'b1 || o_func !== MIDSCALE) begin errors++; $display("FAIL prime_entry state=%0d ce=%b func=%h required=1 1 8000", o_state, o_ce, o_func); end
    wait_state(2'd2, 40, n);
    checks++; if (o_state !== 2'd2 || n != 10) begin errors++; $display("FAIL prime_len state=%0d cycles=%0d required=2 10", o_state, n); end
    for (int k = 0; k < 4; k++) begin
      wait_strobe(40, n, ok);
      checks++; if (!ok || n != 10) begin errors++; $display("FAIL startup_spacing strobe=%b cycles=%0d required=1 10", ok, n); end
    end
  endtask

  task automatic test_underrun();
    int n;
    bit ok;
    push_sample(16'd1234, 1'b1);
    push_sample(16'd65080, 1'b1);
    wait_strobe(40, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL underrun_pop1 strobe=%b required=1", ok); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n != 10) begin errors++; $display("FAIL underrun_pop2 strobe=%b cycles=%0d required=1 10", ok, n); end
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_early o_underrun=%b required=0", o_underrun); end
    n = 0;
    while (o_underrun !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    checks++; if (o_underrun !== 1'b1 || n != 10) begin errors++; $display("FAIL underrun_set flag=%b cycles=%0d required=1 10", o_underrun, n); end
    checks++; if (o_func !== 16'd65080 || o_sample_strobe !== 1'b0) begin errors++; $display("FAIL underrun_hold func=%h strobe=%b required=fe38 0", o_func, o_sample_strobe); end
    i_clr_underrun = 1'b1;
    @(negedge i_clk);
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear flag=%b required=0", o_underrun); end
    n = 0;
    while (o_underrun !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    checks++; if (o_underrun !== 1'b1 || n != 9) begin errors++; $display("FAIL underrun_set_wins flag=%b cycles=%0d required=1 9", o_underrun, n); end
    @(negedge i_clk);
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_reclear flag=%b required=0", o_underrun); end
    i_clr_underrun = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] seq;
    int accepted, first_block, n;
    bit acc;
    seq = 16'h1000;
    accepted = 0;
    first_block = -1;
    i_div = 12'd99;
    for (int i = 0; i < 320; i++) begin
      i_s_valid = 1'b1;
      i_s_data  = seq;
      acc = o_s_ready;
      if (!acc && first_block < 0) first_block = accepted;
      @(negedge i_clk);
      if (acc) begin exp_q.push_back(seq); seq++; accepted++; end
    end
    i_s_valid = 1'b0;
    checks++; if (first_block != 8) begin errors++; $display("FAIL bp_full_at accepted=%0d required=8", first_block); end
    checks++; if (accepted <= 8) begin errors++; $display("FAIL bp_refill accepted=%0d required=more than 8", accepted); end
    i_div = 12'd3;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge i_clk); n++; end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_out remaining=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_drain();
    logic [DATA_W-1:0] ramp [2];
    logic [DATA_W-1:0] prev;
    int n;
    bit ok;
    ramp = '{16'h8100, 16'h8000};
    push_sample(16'h8200, 1'b1);
    wait_strobe(20, n, ok);
    checks++; if (!ok || o_func !== 16'h8200) begin errors++; $display("FAIL drain_start strobe=%b func=%h required=1 8200", ok, o_func); end
    i_div = 12'd20;
    for (int k = 0; k < 4; k++) push_sample(16'hAAAA, 1'b0);
    i_enable = 1'b0;
    @(negedge i_clk);
    checks++; if (o_state !== 2'd3 || o_s_ready !== 1'b0) begin errors++; $display("FAIL drain_entry state=%0d ready=%b required=3 0", o_state, o_s_ready); end
    prev = 16'h8200;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (o_func === prev && n < 30) begin @(negedge i_clk); n++; end
      checks++; if (o_func !== ramp[k]) begin errors++; $display("FAIL drain_step%0d o_func=%h required=%h", k, o_func, ramp[k]); end
      prev = ramp[k];
    end
    wait_state(2'd0, 30, n);
    checks++; if (o_state !== 2'd0 || o_ce !== 1'b0 || o_func !== MIDSCALE) begin errors++; $display("FAIL drain_idle state=%0d ce=%b func=%h required=0 0 8000", o_state, o_ce, o_func); end
    checks++; if (o_s_ready !== 1'b1) begin errors++; $display("FAIL drain_ready o_s_ready=%b required=1", o_s_ready); end
    i_div = 12'd0;
    i_enable = 1'b1;
    repeat (6) @(negedge i_clk);
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL drain_flushed state=%0d required=1", o_state); end
  endtask

  task automatic test_drain_low();
    logic [DATA_W-1:0] vals [4];
    logic [DATA_W-1:0] ramp [2];
    logic [DATA_W-1:0] prev;
    int n;
    bit ok;
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h7E50};
    ramp = '{16'h7F50, 16'h8000};
    for (int k = 0; k < 4; k++) push_sample(vals[k], 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_strobe(10, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fast_pop%0d strobe=%b required=1", k, ok); end
    end
    i_enable = 1'b0;
    prev = 16'h7E50;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (o_func === prev && n < 10) begin @(negedge i_clk); n++; end
      checks++; if (o_func !== ramp[k]) begin errors++; $display("FAIL ramp_up%0d o_func=%h required=%h", k, o_func, ramp[k]); end
      prev = ramp[k];
    end
    wait_state(2'd0, 10, n);
    checks++; if (o_state !== 2'd0 || o_func !== MIDSCALE) begin errors++; $display("FAIL ramp_up_idle state=%0d func=%h required=0 8000", o_state, o_func); end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    i_div = 12'd9;
    for (int k = 0; k < 8; k++) push_sample(16'h4000 + 16'(k), 1'b1);
    i_enable = 1'b1;
    wait_state(2'd2, 40, n);
    wait_strobe(40, n, ok);
    checks++; if (o_state !== 2'd2 || !ok) begin errors++; $display("FAIL ar_run state=%0d strobe=%b required=2 1", o_state, ok); end
    #2 i_res = 1'b0;
    #1;
    checks++; if (o_func !== MIDSCALE || o_ce !== 1'b0 || o_s_ready !== 1'b0) begin errors++; $display("FAIL ar_outputs func=%h ce=%b ready=%b required=8000 0 0", o_func, o_ce, o_s_ready); end
    checks++; if (o_sample_strobe !== 1'b0 || o_underrun !== 1'b0 || o_state !== 2'd0) begin errors++; $display("FAIL ar_flags strobe=%b underrun=%b state=%0d required=0 0 0", o_sample_strobe, o_underrun, o_state); end
    exp_q.delete();
    i_enable = 1'b0;
    @(negedge i_clk);
    i_res = 1'b1;
    @(negedge i_clk);
    checks++; if (o_state !== 2'd0 || o_s_ready !== 1'b1) begin errors++; $display("FAIL ar_release state=%0d ready=%b required=0 1", o_state, o_s_ready); end
    i_div = 12'd0;
    i_enable = 1'b1;
    repeat (6) @(negedge i_clk);
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL ar_fifo_discarded state=%0d required=1", o_state); end
    i_enable = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_underrun();
    test_backpressure();
    test_drain();
    test_drain_low();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
